// File: rtl/gpr_mp_sb.sv
// gpr_mp_sb: general-purpose register file with two prioritised write lanes,
// per-port write-to-read bypass and a pending-writeback scoreboard.
// Optional feature macro: GPR_PARITY_EN (per-register even parity + force_par_flip).
module gpr_mp_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned RD_PORTS = 2,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   we_,
    input  logic [2*AW-1:0]              wr_addr,
    input  logic [2*DATA_W-1:0]          wr_data,
    input  logic [RD_PORTS*AW-1:0]       rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         iss_valid,
    input  logic [AW-1:0]                iss_addr,
    output logic                         iss_ready,
    output logic [CNT_W-1:0]             pend_cnt,
`ifdef GPR_PARITY_EN
    input  logic                         force_par_flip,
`endif
    output logic [RD_PORTS-1:0]          par_err
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef GPR_PARITY_EN
    logic [DEPTH-1:0]  par_mem;
`endif
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [DEPTH-1:0]  clr;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [AW-1:0]     wa [2];
    logic [DATA_W-1:0] wd [2];
    logic [1:0]        wen;
    logic              iss_ok;
    logic              accept;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    // Unpack write lanes; a lane really writes only for a nonzero, in-range address.
    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            wa[n]  = wr_addr[n*AW +: AW];
            wd[n]  = wr_data[n*DATA_W +: DATA_W];
            wen[n] = ~we_[n] & (wa[n] != '0) & in_range(wa[n]);
        end
    end

    // Register array update; lane 1 wins on an address collision, x0 never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
`ifdef GPR_PARITY_EN
            par_mem <= '0;
`endif
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (wen[1] && wa[1] == AW'(i)) begin
                    mem[i] <= wd[1];
`ifdef GPR_PARITY_EN
                    par_mem[i] <= (^wd[1]) ^ force_par_flip;
`endif
                end else if (wen[0] && wa[0] == AW'(i)) begin
                    mem[i] <= wd[0];
`ifdef GPR_PARITY_EN
                    par_mem[i] <= (^wd[0]) ^ force_par_flip;
`endif
                end
            end
        end
    end

    // Writeback clear vector: any lane writing an address clears its pending bit.
    always_comb begin
        clr = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            clr[a] = (~we_[0] & (wa[0] == AW'(a))) | (~we_[1] & (wa[1] == AW'(a)));
        end
    end

    // Read ports: x0 and out-of-range read 0, lane 1 bypass, lane 0 bypass, then array.
    always_comb begin
        logic [AW-1:0] ra;
        rd_data = '0;
        rd_busy = '0;
        par_err = '0;
        ra      = '0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            ra = rd_addr[p*AW +: AW];
            if (reset && ra != '0 && in_range(ra)) begin
                if (wen[1] && wa[1] == ra) begin
                    rd_data[p*DATA_W +: DATA_W] = wd[1];
                end else if (wen[0] && wa[0] == ra) begin
                    rd_data[p*DATA_W +: DATA_W] = wd[0];
                end else begin
                    rd_data[p*DATA_W +: DATA_W] = mem[ra];
`ifdef GPR_PARITY_EN
                    par_err[p] = (^mem[ra]) ^ par_mem[ra];
`endif
                end
                rd_busy[p] = pend[ra] & ~clr[ra];
            end
        end
    end

    // Issue acceptance: WAW-blocked only when pending and not being written back now.
    always_comb begin
        iss_ok = (iss_addr == '0) | ~in_range(iss_addr) | ~pend[iss_addr] | clr[iss_addr];
        accept = iss_valid & iss_ok & (iss_addr != '0) & in_range(iss_addr);
    end

    assign iss_ready = iss_ok;

    // Scoreboard next state (set beats clear) and its popcount.
    always_comb begin
        pend_nxt = '0;
        cnt_nxt  = '0;
        for (int unsigned a = 1; a < DEPTH; a++) begin
            pend_nxt[a] = (pend[a] & ~clr[a]) | (accept & (iss_addr == AW'(a)));
            cnt_nxt     = cnt_nxt + CNT_W'(pend_nxt[a]);
        end
    end

    // Scoreboard and pending count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_gpr_mp_sb.sv
// Directed bench for gpr_mp_sb (default parameters). Build with +define+GPR_PARITY_EN
// to include the parity steps.
module tb_gpr_mp_sb;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned RD_PORTS = 2;
    localparam int unsigned AW       = 5;
    localparam int unsigned CNT_W    = 6;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [1:0]                 we_;
    logic [2*AW-1:0]            wr_addr;
    logic [2*DATA_W-1:0]        wr_data;
    logic [RD_PORTS*AW-1:0]     rd_addr;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_busy;
    logic                       iss_valid;
    logic [AW-1:0]              iss_addr;
    logic                       iss_ready;
    logic [CNT_W-1:0]           pend_cnt;
    logic [RD_PORTS-1:0]        par_err;
`ifdef GPR_PARITY_EN
    logic                       force_par_flip = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    gpr_mp_sb dut (
        .clk       (clk),
        .reset     (reset),
        .we_       (we_),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .pend_cnt  (pend_cnt),
`ifdef GPR_PARITY_EN
        .force_par_flip (force_par_flip),
`endif
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [1:0] we, input logic [AW-1:0] a1, input logic [DATA_W-1:0] d1,
                      input logic [AW-1:0] a0, input logic [DATA_W-1:0] d0);
        we_     = we;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic wr_idle();
        we_ = 2'b11;
    endtask

    initial begin
        reset     = 1'b0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        wr(2'b00, 5'd5, 32'hDEAD_BEEF, 5'd5, 32'h1234_5678);
        set_rd(5'd5, 5'd5);
        #12;
        // Reset held: bypass and array both suppressed.
        chk("rst_rd0", 64'(rd_data[31:0]), 64'h0);
        chk("rst_rd1", 64'(rd_data[63:32]), 64'h0);
        chk("rst_iss_ready", 64'(iss_ready), 64'h1);
        chk("rst_par", 64'(par_err), 64'h0);
        wr_idle();
        step();
        reset = 1'b1;
        #2;
        for (int a = 0; a < 32; a++) begin
            set_rd(AW'(a), AW'(31 - a));
            #1;
            chk("init_rd0", 64'(rd_data[31:0]), 64'h0);
            chk("init_rd1", 64'(rd_data[63:32]), 64'h0);
            chk("init_busy", 64'(rd_busy), 64'h0);
        end
        chk("init_cnt", 64'(pend_cnt), 64'h0);
        chk("init_iss_ready", 64'(iss_ready), 64'h1);
        step();

        // Same-address write on both lanes: lane 1 wins in bypass and in the array.
        wr(2'b00, 5'd5, 32'hDEAD_BEEF, 5'd5, 32'h1234_5678);
        set_rd(5'd5, 5'd5);
        #1;
        chk("x5_byp0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("x5_byp1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
        step();
        wr_idle();
        #1;
        chk("x5_arr0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("x5_arr1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
        chk("x5_par", 64'(par_err), 64'h0);

        // x0 write discarded; lane 0 alone bypasses x6.
        wr(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF);
        set_rd(5'd0, 5'd0);
        #1;
        chk("x0_byp", 64'(rd_data[31:0]), 64'h0);
        step();
        wr(2'b10, 5'd0, 32'h0, 5'd6, 32'h0000_0066);
        set_rd(5'd0, 5'd6);
        #1;
        chk("x0_arr", 64'(rd_data[31:0]), 64'h0);
        chk("x6_lane0_byp", 64'(rd_data[63:32]), 64'h66);
        step();
        wr_idle();

        // Issue x7, then WAW-blocked re-issue.
        iss_valid = 1'b1;
        iss_addr  = 5'd7;
        #1;
        chk("x7_iss_ready", 64'(iss_ready), 64'h1);
        chk("x7_cnt_before_edge", 64'(pend_cnt), 64'h0);
        step();
        iss_valid = 1'b0;
        set_rd(5'd7, 5'd5);
        #1;
        chk("x7_cnt", 64'(pend_cnt), 64'h1);
        chk("x7_busy", 64'(rd_busy), 64'h1);
        iss_valid = 1'b1;
        #1;
        chk("x7_reiss_blocked", 64'(iss_ready), 64'h0);
        step();
        chk("x7_cnt_hold", 64'(pend_cnt), 64'h1);

        // Writeback of x7 together with re-issue: ready, bypass, set wins.
        wr(2'b10, 5'd0, 32'h0, 5'd7, 32'h0000_00A5);
        #1;
        chk("x7_wb_ready", 64'(iss_ready), 64'h1);
        chk("x7_wb_busy", 64'(rd_busy), 64'h0);
        chk("x7_wb_byp", 64'(rd_data[31:0]), 64'hA5);
        step();
        wr_idle();
        iss_valid = 1'b0;
        #1;
        chk("x7_setwins_cnt", 64'(pend_cnt), 64'h1);
        chk("x7_setwins_busy", 64'(rd_busy), 64'h1);
        chk("x7_arr", 64'(rd_data[31:0]), 64'hA5);

        // Drain x7, then issue x3, x4, x9 and retire x3/x9 on both lanes.
        wr(2'b01, 5'd7, 32'h0000_00A5, 5'd0, 32'h0);
        step();
        wr_idle();
        chk("x7_drain_cnt", 64'(pend_cnt), 64'h0);
        iss_valid = 1'b1;
        iss_addr  = 5'd3;
        step();
        chk("cnt_1", 64'(pend_cnt), 64'h1);
        iss_addr = 5'd4;
        step();
        chk("cnt_2", 64'(pend_cnt), 64'h2);
        iss_addr = 5'd9;
        step();
        chk("cnt_3", 64'(pend_cnt), 64'h3);
        iss_valid = 1'b0;
        wr(2'b00, 5'd9, 32'h0000_0009, 5'd3, 32'h0000_0003);
        set_rd(5'd3, 5'd9);
        #1;
        chk("wb_busy_clear", 64'(rd_busy), 64'h0);
        step();
        wr_idle();
        chk("cnt_after_wb", 64'(pend_cnt), 64'h1);
        set_rd(5'd4, 5'd9);
        #1;
        chk("x4_still_busy", 64'(rd_busy), 64'h1);
        iss_valid = 1'b1;
        iss_addr  = 5'd0;
        #1;
        chk("x0_iss_ready", 64'(iss_ready), 64'h1);
        step();
        chk("x0_iss_cnt", 64'(pend_cnt), 64'h1);

        // Issue x2, x6, then a mid-cycle reset pulse.
        iss_addr = 5'd2;
        step();
        iss_addr = 5'd6;
        step();
        iss_valid = 1'b0;
        set_rd(5'd5, 5'd7);
        #1;
        chk("pre_rst_cnt", 64'(pend_cnt), 64'h3);
        chk("pre_rst_x5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        reset = 1'b0;
        #1;
        chk("async_rst_cnt", 64'(pend_cnt), 64'h0);
        chk("async_rst_rd0", 64'(rd_data[31:0]), 64'h0);
        chk("async_rst_rd1", 64'(rd_data[63:32]), 64'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("post_rst_x5", 64'(rd_data[31:0]), 64'h0);
        chk("post_rst_x7", 64'(rd_data[63:32]), 64'h0);
        step();
        set_rd(5'd2, 5'd6);
        #1;
        chk("post_rst_busy", 64'(rd_busy), 64'h0);
        chk("post_rst_cnt", 64'(pend_cnt), 64'h0);

`ifdef GPR_PARITY_EN
        // Flipped-parity write: bypass read is clean, later array read flags.
        wr(2'b10, 5'd0, 32'h0, 5'd10, 32'h0000_000F);
        force_par_flip = 1'b1;
        set_rd(5'd10, 5'd5);
        #1;
        chk("par_byp_flip", 64'(par_err), 64'h0);
        step();
        wr_idle();
        force_par_flip = 1'b0;
        #1;
        chk("par_err_set", 64'(par_err), 64'h1);
        chk("par_data", 64'(rd_data[31:0]), 64'hF);
        wr(2'b10, 5'd0, 32'h0, 5'd10, 32'h0000_000F);
        #1;
        chk("par_byp_clean", 64'(par_err), 64'h0);
        step();
        wr_idle();
        #1;
        chk("par_err_clear", 64'(par_err), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
